muldiv_ctrl: RTL

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 33 +++
 rtl/muldiv_ctrl_div_step.sv | 23 ++
 rtl/muldiv_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared constants and types for the EX-stage multiply/divide controller:
// op and state encodings, divide iteration count, and HI/LO write constants.
package muldiv_ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

    localparam logic              RstEnable    = 1'b1;
    localparam logic              WriteEnable  = 1'b1;
    localparam logic              WriteDisable = 1'b0;
    localparam logic [DATA_W-1:0] ZeroWord     = '0;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_MUL     = 2'b01,
        S_DIV_ON  = 2'b10,
        S_DIV_END = 2'b11
    } state_e;

    // Magnitude of v when treated as signed (sgn=1), raw value otherwise.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
        return (sgn && v[DATA_W-1]) ? (ZeroWord - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_step.sv
// One restoring radix-2 division iteration: shift {rem,quot} left by one and
// subtract the divisor when it fits, shifting the resulting quotient bit in.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quot,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quot
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    assign w_shifted = {i_rem, i_quot[WIDTH-1]};
    assign w_diff    = w_shifted - {1'b0, i_divisor};
    assign w_fits    = (w_shifted >= {1'b0, i_divisor});
    assign o_rem     = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign o_quot    = {i_quot[WIDTH-2:0], w_fits};

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller: single-cycle MULT/MULTU, 32-cycle restoring
// DIV/DIVU with stall and annul, registered HI/LO write port.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             annul_i,
    output logic             stall_o,
    output logic             we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

    state_e             r_state;
    state_e             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_we;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_is_div;
    logic               w_signed_div;
    logic               w_b_zero;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_step_rem;
    logic [WIDTH-1:0]   w_step_quot;
    logic               w_we_d;
    logic [WIDTH-1:0]   w_hi_d;
    logic [WIDTH-1:0]   w_lo_d;

    assign w_accept     = start_i && !annul_i;
    assign w_is_div     = op_i[1];
    assign w_signed_div = (op_i == OP_DIV);
    assign w_b_zero     = (opb_i == '0);

    // One 64x64 multiplier serves both forms: op_i[0] selects zero vs sign extension.
    assign w_ext_a = {{WIDTH{~op_i[0] & opa_i[WIDTH-1]}}, opa_i};
    assign w_ext_b = {{WIDTH{~op_i[0] & opb_i[WIDTH-1]}}, opb_i};
    assign w_prod  = w_ext_a * w_ext_b;

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .i_rem     (r_rem),
        .i_quot    (r_quot),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_quot    (w_step_quot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) r_state <= S_IDLE;
        else                  r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_is_div)    w_next = S_MUL;
                    else if (w_b_zero) w_next = S_DIV_END;
                    else              w_next = S_DIV_ON;
                end
            end
            S_MUL:     w_next = S_IDLE;
            S_DIV_ON: begin
                if (annul_i)                w_next = S_IDLE;
                else if (r_cnt == CNT_LAST) w_next = S_DIV_END;
            end
            S_DIV_END: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Write-port values are computed for the state being entered, so we_o is
    // high during MUL/DIV_END themselves.
    always_comb begin
        stall_o = 1'b0;
        busy_o  = (r_state != S_IDLE);
        w_we_d  = WriteDisable;
        w_hi_d  = r_hi;
        w_lo_d  = r_lo;
        case (r_state)
            S_IDLE: begin
                stall_o = start_i && w_is_div && !w_b_zero;
                if (w_accept && !w_is_div) begin
                    w_we_d = WriteEnable;
                    w_hi_d = w_prod[2*WIDTH-1:WIDTH];
                    w_lo_d = w_prod[WIDTH-1:0];
                end else if (w_accept && w_b_zero) begin
                    w_we_d = WriteEnable;
                    w_hi_d = opa_i;
                    w_lo_d = '1;
                end
            end
            S_DIV_ON: begin
                stall_o = 1'b1;
                if (!annul_i && r_cnt == CNT_LAST) begin
                    w_we_d = WriteEnable;
                    w_hi_d = r_neg_r ? (ZeroWord - w_step_rem)  : w_step_rem;
                    w_lo_d = r_neg_q ? (ZeroWord - w_step_quot) : w_step_quot;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            r_we      <= WriteDisable;
            r_hi      <= ZeroWord;
            r_lo      <= ZeroWord;
            r_cnt     <= '0;
            r_rem     <= ZeroWord;
            r_quot    <= ZeroWord;
            r_divisor <= ZeroWord;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
        end else begin
            r_we <= w_we_d;
            r_hi <= w_hi_d;
            r_lo <= w_lo_d;
            if (r_state == S_IDLE && w_accept && w_is_div && !w_b_zero) begin
                r_cnt     <= '0;
                r_rem     <= ZeroWord;
                r_quot    <= mag(opa_i, w_signed_div);
                r_divisor <= mag(opb_i, w_signed_div);
                r_neg_q   <= w_signed_div && (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                r_neg_r   <= w_signed_div && opa_i[WIDTH-1];
            end else if (r_state == S_DIV_ON) begin
                r_cnt  <= r_cnt + 1'b1;
                r_rem  <= w_step_rem;
                r_quot <= w_step_quot;
            end
        end
    end

    assign we_o = r_we;
    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
